pipe_hazard_ctrl: RTL and testbench

//  Central sequencer for the 5-stage pipeline registers (IF/ID, ID/EX) and the PC register.

---
 rtl/pipe_hazard_ctrl_pkg.sv | 40 ++++
 rtl/pipe_hazard_ctrl_hazard_detect.sv | 44 ++++
 rtl/pipe_hazard_ctrl.sv | 138 +++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard / interrupt-entry sequencer:
// FSM encodings, default register address width and the interrupt vector.
package pipe_hazard_ctrl_pkg;

    localparam int unsigned RegAddrWDefault = 3;

    localparam int unsigned StateW = 3;

    localparam logic [StateW-1:0] StRun     = 3'd0;
    localparam logic [StateW-1:0] StDrain   = 3'd1;
    localparam logic [StateW-1:0] StPushPc  = 3'd2;
    localparam logic [StateW-1:0] StPushFlg = 3'd3;
    localparam logic [StateW-1:0] StVector  = 3'd4;

    // Address the PC mux substitutes when pc_load_vec_o is high.
    localparam logic [15:0] IntVectorAddr = 16'h0040;

    // Packed view of the strobes, handy for decode tables and checking.
    typedef struct packed {
        logic pc_en;
        logic ifid_en;
        logic ifid_flush;
        logic idex_flush;
        logic int_push_pc;
        logic int_push_flg;
        logic pc_load_vec;
        logic int_ack;
    } ctrl_t;

    localparam ctrl_t CtrlReset  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam ctrl_t CtrlNormal = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam ctrl_t CtrlStall  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam ctrl_t CtrlBranch = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam ctrl_t CtrlDrain  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

    function automatic logic src_hit(input logic used, input logic addr_eq, input logic wr_en);
        return used & addr_eq & wr_en;
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// Combinational RAW comparator between the ID sources and in-flight destinations.
// FORWARDING_EN selects the load-use-only check; otherwise EX and MEM matches both stall.
module hazard_detect
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int unsigned REG_ADDR_W = RegAddrWDefault
) (
    input  logic [REG_ADDR_W-1:0] id_rs1_i,
    input  logic [REG_ADDR_W-1:0] id_rs2_i,
    input  logic                  id_rs1_used_i,
    input  logic                  id_rs2_used_i,
    input  logic [REG_ADDR_W-1:0] ex_rd_i,
    input  logic                  ex_wr_en_i,
    input  logic                  ex_is_load_i,
    input  logic [REG_ADDR_W-1:0] mem_rd_i,
    input  logic                  mem_wr_en_i,
    output logic                  hazard_o
);

    logic ex_hit;

    assign ex_hit = src_hit(id_rs1_used_i, id_rs1_i == ex_rd_i, ex_wr_en_i)
                  | src_hit(id_rs2_used_i, id_rs2_i == ex_rd_i, ex_wr_en_i);

`ifdef FORWARDING_EN
    // Only a load result arrives too late to forward into EX.
    assign hazard_o = ex_is_load_i & ex_hit;

    logic unused_mem;
    assign unused_mem = ^{mem_rd_i, mem_wr_en_i};
`else
    logic mem_hit;

    assign mem_hit = src_hit(id_rs1_used_i, id_rs1_i == mem_rd_i, mem_wr_en_i)
                   | src_hit(id_rs2_used_i, id_rs2_i == mem_rd_i, mem_wr_en_i);

    // WB needs no check: the register file writes in the first half-cycle.
    assign hazard_o = ex_hit | mem_hit;

    logic unused_load;
    assign unused_load = ex_is_load_i;
`endif

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline register sequencer: stall/flush strobes plus the interrupt-entry FSM.
// Hazard rules depend on FORWARDING_EN (see hazard_detect).
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int unsigned REG_ADDR_W   = RegAddrWDefault,
    parameter int unsigned DRAIN_CYCLES = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [REG_ADDR_W-1:0] id_rs1_i,
    input  logic [REG_ADDR_W-1:0] id_rs2_i,
    input  logic                  id_rs1_used_i,
    input  logic                  id_rs2_used_i,
    input  logic [REG_ADDR_W-1:0] ex_rd_i,
    input  logic                  ex_wr_en_i,
    input  logic                  ex_is_load_i,
    input  logic [REG_ADDR_W-1:0] mem_rd_i,
    input  logic                  mem_wr_en_i,
    input  logic                  br_taken_i,
    input  logic                  int_req_i,
    output logic                  pc_en_o,
    output logic                  ifid_en_o,
    output logic                  ifid_flush_o,
    output logic                  idex_flush_o,
    output logic                  int_push_pc_o,
    output logic                  int_push_flg_o,
    output logic                  pc_load_vec_o,
    output logic                  int_ack_o
);

    localparam int unsigned CntW = $clog2(DRAIN_CYCLES + 1);
    localparam logic [CntW-1:0] DrainLast = CntW'(DRAIN_CYCLES - 1);

    logic [StateW-1:0] state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              hazard;
    ctrl_t             ctrl;

    hazard_detect #(
        .REG_ADDR_W (REG_ADDR_W)
    ) u_hazard_detect (
        .id_rs1_i      (id_rs1_i),
        .id_rs2_i      (id_rs2_i),
        .id_rs1_used_i (id_rs1_used_i),
        .id_rs2_used_i (id_rs2_used_i),
        .ex_rd_i       (ex_rd_i),
        .ex_wr_en_i    (ex_wr_en_i),
        .ex_is_load_i  (ex_is_load_i),
        .mem_rd_i      (mem_rd_i),
        .mem_wr_en_i   (mem_wr_en_i),
        .hazard_o      (hazard)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StRun: begin
                if (int_req_i && !br_taken_i && !hazard) begin
                    state_d = StDrain;
                    cnt_d   = '0;
                end
            end
            StDrain: begin
                if (cnt_q == DrainLast) begin
                    state_d = StPushPc;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StPushPc:  state_d = StPushFlg;
            StPushFlg: state_d = StVector;
            StVector:  state_d = StRun;
            default: begin
                state_d = StRun;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StRun;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Branch outranks stall: the stalled instruction is on the wrong path.
    always_comb begin
        ctrl = CtrlDrain;
        if (reset) begin
            ctrl = CtrlReset;
        end else begin
            unique case (state_q)
                StRun: begin
                    if (br_taken_i) begin
                        ctrl = CtrlBranch;
                    end else if (hazard) begin
                        ctrl = CtrlStall;
                    end else begin
                        ctrl = CtrlNormal;
                    end
                end
                StDrain: ctrl = CtrlDrain;
                StPushPc: begin
                    ctrl             = CtrlDrain;
                    ctrl.int_push_pc = 1'b1;
                end
                StPushFlg: begin
                    ctrl              = CtrlDrain;
                    ctrl.int_push_flg = 1'b1;
                end
                StVector: begin
                    ctrl             = CtrlDrain;
                    ctrl.pc_en       = 1'b1;
                    ctrl.pc_load_vec = 1'b1;
                    ctrl.int_ack     = 1'b1;
                end
                default: ctrl = CtrlDrain;
            endcase
        end
    end

    assign pc_en_o        = ctrl.pc_en;
    assign ifid_en_o      = ctrl.ifid_en;
    assign ifid_flush_o   = ctrl.ifid_flush;
    assign idex_flush_o   = ctrl.idex_flush;
    assign int_push_pc_o  = ctrl.int_push_pc;
    assign int_push_flg_o = ctrl.int_push_flg;
    assign pc_load_vec_o  = ctrl.pc_load_vec;
    assign int_ack_o      = ctrl.int_ack;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: stalls, branch flushes and interrupt entry.
// Outputs compared as {pc_en, ifid_en, ifid_flush, idex_flush, push_pc, push_flg, load_vec, ack}.
module tb_pipe_hazard_ctrl;

    localparam logic [7:0] ExpReset  = 8'b0011_0000;
    localparam logic [7:0] ExpNorm   = 8'b1100_0000;
    localparam logic [7:0] ExpStall  = 8'b0001_0000;
    localparam logic [7:0] ExpBranch = 8'b1111_0000;
    localparam logic [7:0] ExpDrain  = 8'b0011_0000;
    localparam logic [7:0] ExpPushPc = 8'b0011_1000;
    localparam logic [7:0] ExpPushFl = 8'b0011_0100;
    localparam logic [7:0] ExpVector = 8'b1011_0011;

`ifdef FORWARDING_EN
    localparam logic [7:0] ExpAluDep = ExpNorm;
`else
    localparam logic [7:0] ExpAluDep = ExpStall;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] id_rs1, id_rs2, ex_rd, mem_rd;
    logic       id_rs1_used, id_rs2_used, ex_wr_en, ex_is_load, mem_wr_en;
    logic       br_taken, int_req;
    logic       pc_en, ifid_en, ifid_flush, idex_flush;
    logic       int_push_pc, int_push_flg, pc_load_vec, int_ack;
    logic [7:0] outs;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    assign outs = {pc_en, ifid_en, ifid_flush, idex_flush,
                   int_push_pc, int_push_flg, pc_load_vec, int_ack};

    pipe_hazard_ctrl #(
        .REG_ADDR_W   (3),
        .DRAIN_CYCLES (3)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .id_rs1_i       (id_rs1),
        .id_rs2_i       (id_rs2),
        .id_rs1_used_i  (id_rs1_used),
        .id_rs2_used_i  (id_rs2_used),
        .ex_rd_i        (ex_rd),
        .ex_wr_en_i     (ex_wr_en),
        .ex_is_load_i   (ex_is_load),
        .mem_rd_i       (mem_rd),
        .mem_wr_en_i    (mem_wr_en),
        .br_taken_i     (br_taken),
        .int_req_i      (int_req),
        .pc_en_o        (pc_en),
        .ifid_en_o      (ifid_en),
        .ifid_flush_o   (ifid_flush),
        .idex_flush_o   (idex_flush),
        .int_push_pc_o  (int_push_pc),
        .int_push_flg_o (int_push_flg),
        .pc_load_vec_o  (pc_load_vec),
        .int_ack_o      (int_ack)
    );

    task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%b expected=%b", tag, got, exp);
        end
    endtask

    // Inputs are set just after a falling edge; outputs sampled 1ns later.
    task automatic step(input string tag, input logic [7:0] exp);
        #1;
        check_eq(tag, outs, exp);
        @(negedge clk);
    endtask

    task automatic clr_in();
        id_rs1 = 3'd0; id_rs2 = 3'd0; ex_rd = 3'd0; mem_rd = 3'd0;
        id_rs1_used = 1'b0; id_rs2_used = 1'b0;
        ex_wr_en = 1'b0; ex_is_load = 1'b0; mem_wr_en = 1'b0;
        br_taken = 1'b0; int_req = 1'b0;
    endtask

    task automatic set_load_use();
        ex_is_load = 1'b1; ex_wr_en = 1'b1; ex_rd = 3'd3;
        id_rs1 = 3'd3; id_rs1_used = 1'b1;
    endtask

    initial begin
        clr_in();
        reset = 1'b1;
        @(negedge clk);
        step("reset_0", ExpReset);
        step("reset_1", ExpReset);
        reset = 1'b0;
        step("run_idle", ExpNorm);

        set_load_use();
        step("load_use", ExpStall);
        clr_in();
        step("load_use_after", ExpNorm);

        set_load_use();
        br_taken = 1'b1;
        step("branch_beats_stall", ExpBranch);
        clr_in();
        step("after_branch", ExpNorm);

        br_taken = 1'b1;
        step("branch_plain", ExpBranch);
        clr_in();

        ex_wr_en = 1'b1; ex_rd = 3'd2; id_rs2 = 3'd2; id_rs2_used = 1'b1;
        step("ex_alu_dep", ExpAluDep);
        clr_in();

        mem_rd = 3'd5; mem_wr_en = 1'b1; id_rs2 = 3'd5; id_rs2_used = 1'b1;
        step("mem_alu_dep", ExpAluDep);
        clr_in();

        set_load_use();
        id_rs1_used = 1'b0;
        mem_rd = 3'd3; mem_wr_en = 1'b1;
        step("rs1_unused", ExpNorm);
        clr_in();

        ex_is_load = 1'b1; ex_wr_en = 1'b1; ex_rd = 3'd0;
        id_rs2 = 3'd0; id_rs2_used = 1'b1;
        step("reg0_hazard", ExpStall);
        clr_in();

        // Interrupt blocked by branch, then by hazard, then accepted.
        int_req = 1'b1; br_taken = 1'b1;
        step("int_vs_branch", ExpBranch);
        br_taken = 1'b0;
        set_load_use();
        step("int_vs_hazard", ExpStall);
        clr_in();
        int_req = 1'b1;
        step("int_accept", ExpNorm);
        step("drain_1", ExpDrain);
        br_taken = 1'b1;
        set_load_use();
        step("drain_2_ignores", ExpDrain);
        clr_in();
        step("drain_3_req_low", ExpDrain);
        step("push_pc", ExpPushPc);
        step("push_flg", ExpPushFl);
        int_req = 1'b1;
        step("vector_ack", ExpVector);

        // Request still high after ack counts as a new entry; reset aborts it.
        step("int_reaccept", ExpNorm);
        step("re_drain_1", ExpDrain);
        step("re_drain_2", ExpDrain);
        step("re_drain_3", ExpDrain);
        reset = 1'b1;
        int_req = 1'b0;
        step("reset_in_push_pc", ExpReset);
        reset = 1'b0;
        step("after_abort_0", ExpNorm);
        step("after_abort_1", ExpNorm);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
